// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, jump function codes and the
// next-PC controller state encoding.
package y86_pkg;

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [3:0] J_ALWAYS = 4'h0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      RET_WAIT = 2'd1,
      HALTED   = 2'd2,
      FAULT    = 2'd3
   } pc_state_t;

   // icodes C-F are not defined by the ISA
   function automatic logic icode_is_invalid(input logic [3:0] icode);
      return icode > I_POP;
   endfunction

endpackage

// File: rtl/pc_next_ctrl_if.sv
// Bundle of fetch/execute/memory resolution inputs and PC outputs of the
// next-PC controller. master drives the pipeline side, slave is the controller.
interface pc_next_ctrl_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned CNT_W  = 64
);
   logic              stall_i;
   logic              f_valid;
   logic [3:0]        f_icode;
   logic [3:0]        f_ifun;
   logic [ADDR_W-1:0] f_valC;
   logic [ADDR_W-1:0] f_valP;
   logic              f_imem_err;
   logic              f_instr_invalid;
   logic              e_mispredict;
   logic [ADDR_W-1:0] e_alt_pc;
   logic              m_ret_valid;
   logic [ADDR_W-1:0] m_ret_addr;
   logic              m_dmem_err;
   logic [ADDR_W-1:0] pc_o;
   logic              fetch_en_o;
   logic [1:0]        state_o;
   logic [ADDR_W-1:0] fault_pc_o;
   logic [CNT_W-1:0]  instr_count_o;
   logic              ras_miss_o;

   modport master (
      output stall_i, f_valid, f_icode, f_ifun, f_valC, f_valP, f_imem_err, f_instr_invalid,
             e_mispredict, e_alt_pc, m_ret_valid, m_ret_addr, m_dmem_err,
      input  pc_o, fetch_en_o, state_o, fault_pc_o, instr_count_o, ras_miss_o
   );

   modport slave (
      input  stall_i, f_valid, f_icode, f_ifun, f_valC, f_valP, f_imem_err, f_instr_invalid,
             e_mispredict, e_alt_pc, m_ret_valid, m_ret_addr, m_dmem_err,
      output pc_o, fetch_en_o, state_o, fault_pc_o, instr_count_o, ras_miss_o
   );
endinterface

// File: rtl/pc_next_ctrl_ras.sv
// Return-address stack: LIFO with push/pop/flush. Pushing when full drops the
// oldest entry. Entry 0 is always the top of stack.
module pc_ras #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty
);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CntW-1:0]  cnt_q;

   // occupancy count; saturates at DEPTH since old entries fall off the bottom
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cnt_q <= '0;
      end else if (push) begin
         if (!full) cnt_q <= cnt_q + CntW'(1);
      end else if (pop && !empty) begin
         cnt_q <= cnt_q - CntW'(1);
      end
   end

   // entry storage shifts down on push and up on pop
   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = DEPTH - 1; i > 0; i--) mem_q[i] <= mem_q[i-1];
         mem_q[0] <= push_data;
      end else if (pop && !empty) begin
         for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      end
   end

   // flags and top-of-stack view
   always_comb begin
      top   = mem_q[0];
      full  = (cnt_q == CntW'(DEPTH));
      empty = (cnt_q == '0);
   end
endmodule

// File: rtl/pc_next_ctrl.sv
// Next-PC controller: registered fetch PC with RUN/RET_WAIT/HALTED/FAULT state,
// mispredict redirect, ret completion and accepted-fetch counter.
// Optional return-address-stack prediction is enabled by defining PC_RAS_EN.
module pc_next_ctrl
   import y86_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 64,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int unsigned       CNT_W     = 64,
   parameter int unsigned       RAS_DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   pc_next_ctrl_if.slave bus
);
   pc_state_t         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fetch_en, accept, active, fault, mispredict, ret_done;

`ifdef PC_RAS_EN
   logic              ras_push, ras_pop, ras_flush, ras_full, ras_empty;
   logic [ADDR_W-1:0] ras_top;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] pend_val_q, pend_val_d;
   logic              ras_check, ras_mismatch;
   logic              ras_miss_q, ras_miss_d;

   pc_ras #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (ADDR_W)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .flush     (ras_flush),
      .push_data (bus.f_valP),
      .top       (ras_top),
      .full      (ras_full),
      .empty     (ras_empty)
   );
`endif

   // event decode feeding the priority chain
   always_comb begin
      fetch_en   = (state_q == RUN) && !bus.stall_i;
      accept     = fetch_en && bus.f_valid;
      active     = (state_q == RUN) || (state_q == RET_WAIT);
      fault      = active && (bus.m_dmem_err ||
                   (accept && (bus.f_imem_err || bus.f_instr_invalid ||
                               icode_is_invalid(bus.f_icode))));
      mispredict = active && bus.e_mispredict;
      ret_done   = (state_q == RET_WAIT) && bus.m_ret_valid;
`ifdef PC_RAS_EN
      ras_check    = pend_q && (state_q == RUN) && bus.m_ret_valid;
      ras_mismatch = ras_check && (bus.m_ret_addr != pend_val_q);
`endif
   end

   // next state and datapath: fault > mispredict > ret resolution > accept > hold
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_pc_d = fault_pc_q;
      cnt_d      = cnt_q;
`ifdef PC_RAS_EN
      ras_push   = 1'b0;
      ras_pop    = 1'b0;
      ras_flush  = 1'b0;
      ras_miss_d = 1'b0;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
`endif
      if (fault) begin
         state_d    = FAULT;
         fault_pc_d = pc_q;
`ifdef PC_RAS_EN
         pend_d     = 1'b0;
`endif
      end else if (mispredict) begin
         state_d = RUN;
         pc_d    = bus.e_alt_pc;
`ifdef PC_RAS_EN
         pend_d  = 1'b0;
`endif
      end else if (ret_done) begin
         state_d = RUN;
         pc_d    = bus.m_ret_addr;
`ifdef PC_RAS_EN
      end else if (ras_mismatch) begin
         // predicted return was wrong: redirect, drop any queued fetch, distrust stack
         pc_d       = bus.m_ret_addr;
         ras_miss_d = 1'b1;
         ras_flush  = 1'b1;
         pend_d     = 1'b0;
`endif
      end else begin
`ifdef PC_RAS_EN
         if (ras_check) pend_d = 1'b0;
`endif
         if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            case (bus.f_icode)
               I_HALT: state_d = HALTED;
               // jXX always predicted taken; execute corrects with e_mispredict
               I_JXX:  pc_d = bus.f_valC;
               I_CALL: begin
                  pc_d = bus.f_valC;
`ifdef PC_RAS_EN
                  ras_push = 1'b1;
`endif
               end
               I_RET: begin
`ifdef PC_RAS_EN
                  if (!ras_empty) begin
                     ras_pop    = 1'b1;
                     pc_d       = ras_top;
                     pend_d     = 1'b1;
                     pend_val_d = ras_top;
                  end else begin
                     state_d = RET_WAIT;
                  end
`else
                  state_d = RET_WAIT;
`endif
               end
               default: pc_d = bus.f_valP;
            endcase
         end
      end
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         fault_pc_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fault_pc_q <= fault_pc_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef PC_RAS_EN
   // pending-prediction tracking and miss pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         ras_miss_q <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         ras_miss_q <= ras_miss_d;
      end
   end
`endif

   // outputs
   always_comb begin
      bus.pc_o          = pc_q;
      bus.fetch_en_o    = fetch_en;
      bus.state_o       = state_q;
      bus.fault_pc_o    = fault_pc_q;
      bus.instr_count_o = cnt_q;
`ifdef PC_RAS_EN
      bus.ras_miss_o    = ras_miss_q;
`else
      bus.ras_miss_o    = 1'b0;
`endif
   end
endmodule

// File: tb/tb_pc_next_ctrl.sv
// Scoreboard bench for pc_next_ctrl: the driver pushes the expected post-edge
// outputs for each cycle; a monitor pops and compares just after every edge.
module tb_pc_next_ctrl;
   import y86_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pc_next_ctrl_if #(.ADDR_W(64), .CNT_W(8)) bus ();

   pc_next_ctrl #(
      .ADDR_W    (64),
      .RESET_PC  (64'h0),
      .CNT_W     (8),
      .RAS_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [63:0] pc;
      pc_state_t   st;
      logic [7:0]  cnt;
      logic [63:0] fpc;
      logic        fen;
      logic        miss;
      string       tag;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: one expectation per clock edge
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({e.tag, ".pc"}, bus.pc_o, e.pc);
         chk({e.tag, ".state"}, 64'(bus.state_o), 64'(e.st));
         chk({e.tag, ".count"}, 64'(bus.instr_count_o), 64'(e.cnt));
         chk({e.tag, ".fault_pc"}, bus.fault_pc_o, e.fpc);
         chk({e.tag, ".fetch_en"}, 64'(bus.fetch_en_o), 64'(e.fen));
         chk({e.tag, ".ras_miss"}, 64'(bus.ras_miss_o), 64'(e.miss));
      end
   end

   task automatic v();
      bus.stall_i = 0; bus.f_valid = 0; bus.f_icode = 0; bus.f_ifun = 0;
      bus.f_valC = 0; bus.f_valP = 0; bus.f_imem_err = 0; bus.f_instr_invalid = 0;
      bus.e_mispredict = 0; bus.e_alt_pc = 0; bus.m_ret_valid = 0; bus.m_ret_addr = 0;
      bus.m_dmem_err = 0;
   endtask

   task automatic fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c,
                        input logic [63:0] p);
      bus.f_valid = 1; bus.f_icode = ic; bus.f_ifun = fn; bus.f_valC = c; bus.f_valP = p;
   endtask

   // push expectation for the coming edge, then advance to the next negedge
   task automatic step(input logic [63:0] pc, input pc_state_t st, input logic [7:0] cnt,
                       input logic [63:0] fpc, input logic miss, input string tag);
      exp_t x;
      x.pc = pc; x.st = st; x.cnt = cnt; x.fpc = fpc; x.miss = miss; x.tag = tag;
      x.fen = (st == RUN) && !bus.stall_i;
      q.push_back(x);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1; v();
      @(negedge clk);
      fetch(I_IRMOV, 0, 0, 64'h77);       step(64'h00, RUN, 0, 0, 0, "reset");
      rst = 0;
      v(); fetch(I_IRMOV, 0, 0, 64'h0A);  step(64'h0A, RUN, 1, 0, 0, "irmovq");
      v(); fetch(I_JXX, 1, 64'h40, 64'h13); step(64'h40, RUN, 2, 0, 0, "jxx_taken");
      v(); fetch(I_NOP, 0, 0, 64'h99);
      bus.stall_i = 1; bus.e_mispredict = 1; bus.e_alt_pc = 64'h13;
      step(64'h13, RUN, 2, 0, 0, "mispredict_stall");
      v(); fetch(I_JXX, J_ALWAYS, 64'h20, 64'h15); step(64'h20, RUN, 3, 0, 0, "jmp20");
      v(); fetch(I_RET, 0, 0, 64'h21);    step(64'h20, RET_WAIT, 4, 0, 0, "ret_wait");
      for (int i = 0; i < 3; i++) begin
         v(); fetch(I_NOP, 0, 0, 64'h99);  step(64'h20, RET_WAIT, 4, 0, 0, "ret_hold");
      end
      v(); bus.m_ret_valid = 1; bus.m_ret_addr = 64'h55;
      step(64'h55, RUN, 4, 0, 0, "ret_done");
      v(); bus.m_ret_valid = 1; bus.m_ret_addr = 64'h99; fetch(I_NOP, 0, 0, 64'h56);
      step(64'h56, RUN, 5, 0, 0, "ret_valid_ignored");
      v(); fetch(I_JXX, J_ALWAYS, 64'h30, 64'h58); step(64'h30, RUN, 6, 0, 0, "jmp30");
      v(); fetch(4'hC, 0, 0, 64'h31); bus.f_instr_invalid = 1;
      step(64'h30, FAULT, 6, 64'h30, 0, "invalid_fault");
      v(); fetch(I_NOP, 0, 0, 64'h99); bus.e_mispredict = 1; bus.e_alt_pc = 64'h77;
      bus.m_dmem_err = 1;
      step(64'h30, FAULT, 6, 64'h30, 0, "fault_sticky");
      rst = 1; v();                       step(64'h00, RUN, 0, 0, 0, "reset_after_fault");
      rst = 0;
      v(); fetch(I_IRMOV, 0, 0, 64'h08);  step(64'h08, RUN, 1, 0, 0, "to08");
      v(); fetch(I_HALT, 0, 0, 64'h09);   step(64'h08, HALTED, 2, 0, 0, "halt");
      for (int i = 0; i < 10; i++) begin
         v(); fetch(I_NOP, 0, 0, 64'h99); bus.e_mispredict = (i == 3); bus.e_alt_pc = 64'h66;
         bus.m_ret_valid = (i == 5); bus.m_ret_addr = 64'h67;
         step(64'h08, HALTED, 2, 0, 0, "halted_frozen");
      end
      rst = 1; v();                       step(64'h00, RUN, 0, 0, 0, "reset_after_halt");
      rst = 0;
      v(); fetch(I_OPQ, 0, 0, 64'h44);    step(64'h44, RUN, 1, 0, 0, "opq");
      v(); fetch(I_NOP, 0, 0, 64'h99); bus.stall_i = 1; bus.m_dmem_err = 1;
      step(64'h44, FAULT, 1, 64'h44, 0, "dmem_err_stalled");
      rst = 1; v();                       step(64'h00, RUN, 0, 0, 0, "reset3");
      rst = 0;
      v(); fetch(I_NOP, 0, 0, 64'h60);    step(64'h60, RUN, 1, 0, 0, "nop60");
      v(); fetch(I_CMOV, 0, 0, 64'h62); bus.f_imem_err = 1;
      bus.e_mispredict = 1; bus.e_alt_pc = 64'h70;
      step(64'h60, FAULT, 1, 64'h60, 0, "imem_err_over_mispredict");
      rst = 1; v();                       step(64'h00, RUN, 0, 0, 0, "reset4");
      rst = 0;
      for (int i = 0; i < 256; i++) begin
         v(); fetch(I_NOP, 0, 0, 64'h1000 + 64'(i));
         step(64'h1000 + 64'(i), RUN, 8'(i + 1), 0, 0, "count_wrap");
      end
`ifdef PC_RAS_EN
      rst = 1; v();                       step(64'h00, RUN, 0, 0, 0, "reset_ras");
      rst = 0;
      v(); fetch(I_CALL, 0, 64'h100, 64'h1A); step(64'h100, RUN, 1, 0, 0, "ras_call");
      v(); fetch(I_RET, 0, 0, 64'h101);   step(64'h1A, RUN, 2, 0, 0, "ras_ret_pred");
      v(); bus.m_ret_valid = 1; bus.m_ret_addr = 64'h1A;
      step(64'h1A, RUN, 2, 0, 0, "ras_hit");
      v();                                step(64'h1A, RUN, 2, 0, 0, "ras_hit_idle");
      v(); fetch(I_CALL, 0, 64'h100, 64'h1A); step(64'h100, RUN, 3, 0, 0, "ras_call2");
      v(); fetch(I_RET, 0, 0, 64'h101);   step(64'h1A, RUN, 4, 0, 0, "ras_ret_pred2");
      v(); bus.m_ret_valid = 1; bus.m_ret_addr = 64'h2B;
      step(64'h2B, RUN, 4, 0, 1, "ras_miss");
      v();                                step(64'h2B, RUN, 4, 0, 0, "ras_miss_pulse_end");
      v(); fetch(I_CALL, 0, 64'h200, 64'h2C); step(64'h200, RUN, 5, 0, 0, "ras_call3");
      v(); fetch(I_CALL, 0, 64'h300, 64'h201); step(64'h300, RUN, 6, 0, 0, "ras_call4");
      v(); fetch(I_RET, 0, 0, 64'h301);   step(64'h201, RUN, 7, 0, 0, "ras_ret_pred3");
      v(); bus.m_ret_valid = 1; bus.m_ret_addr = 64'h77;
      step(64'h77, RUN, 7, 0, 1, "ras_miss_flush");
      v(); fetch(I_RET, 0, 0, 64'h78);    step(64'h77, RET_WAIT, 8, 0, 0, "ras_flushed_ret");
`endif
      v();
      @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_next_ctrl.md
Name: pc_next_ctrl

Overview:
Parametrised PC-select/update stage for the Y86-64 core. It generalises the per-opcode next-PC mux into a registered PC holder with a run/ret-wait/halt/fault state machine, stall handling, execute-stage branch-mispredict redirect and a retired-fetch counter. It sits between fetch, which consumes pc_o, and the execute/memory stages, which return resolution information.

Parameters:
ADDR_W, 64, PC and address width
RESET_PC, 0, PC value loaded on reset
CNT_W, 64, width of the accepted-instruction counter
RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold PC, no fetch accept
f_valid  in  1  fetch outputs valid this cycle
f_icode  in  4  fetched icode
f_ifun  in  4  fetched ifun
f_valC  in  ADDR_W  fetched constant/destination
f_valP  in  ADDR_W  fall-through PC
f_imem_err  in  1  instruction memory error
f_instr_invalid  in  1  illegal icode
e_mispredict  in  1  jXX predicted taken but not taken
e_alt_pc  in  ADDR_W  correct PC on mispredict
m_ret_valid  in  1  ret target available
m_ret_addr  in  ADDR_W  ret target popped from stack memory
m_dmem_err  in  1  data memory error
pc_o  out  ADDR_W  current fetch PC (registered)
fetch_en_o  out  1  fetch may consume pc_o
state_o  out  2  0 RUN, 1 RET_WAIT, 2 HALTED, 3 FAULT
fault_pc_o  out  ADDR_W  PC of faulting instruction
instr_count_o  out  CNT_W  accepted fetch count
ras_miss_o  out  1  one-cycle pulse, RAS prediction wrong

Behaviour:
- Clock is clk; reset is synchronous, active-high on rst. On rst: pc_o=RESET_PC, state RUN, fault_pc_o=0, instr_count_o=0, ras_miss_o=0, RAS empty. Reset overrides everything, including mid-RET_WAIT.
- fetch_en_o = (state==RUN) && !stall_i, combinational. Accept = fetch_en_o && f_valid.
- Per-edge priority (highest first): rst; fault; e_mispredict; m_ret_valid (in RET_WAIT); accept; hold.
- Fault: m_dmem_err in any non-HALTED state, or accept with f_imem_err or f_instr_invalid, gives FAULT. fault_pc_o <= pc_o. pc_o holds. The counter does not increment.
- e_mispredict in RUN or RET_WAIT: pc_o <= e_alt_pc, state RUN. Honoured even when stall_i=1.
- Accept, next pc_o by f_icode:
  - 0 halt: state HALTED, pc_o holds.
  - 1, 2, 3, 4, 5, 6, A, B: f_valP.
  - 7 jXX: f_valC when f_ifun==0. Otherwise still f_valC (predict taken; execute corrects).
  - 8 call: f_valC.
  - 9 ret: state RET_WAIT, pc_o holds.
  - C-F: invalid (fault).
- Counter: instr_count_o increments by 1 per accept, including halt and ret. It wraps modulo 2^CNT_W.
- RET_WAIT: on m_ret_valid, pc_o <= m_ret_addr and state RUN. m_ret_valid in other states is ignored.
- HALTED and FAULT are sticky until rst. pc_o, the counter and fault_pc_o stay frozen.
- stall_i only blocks accept. Mispredict, ret completion and faults still act.

Optional Feature:
PC_RAS_EN.
- Defined:
  - A RAS_DEPTH-entry stack is added. Call accept pushes f_valP; when full, the oldest entry is dropped.
  - Ret accept with a non-empty stack pops the top, sets pc_o to it and stays in RUN. The popped value is kept in a pending register.
  - When m_ret_valid arrives for that ret, it is compared with the pending value. On mismatch: pc_o <= m_ret_addr, pulse ras_miss_o, flush the stack.
  - Ret with an empty stack uses RET_WAIT as normal.
  - Mispredict or fault clears the pending-ret flag.
- Not defined: no stack, ret always enters RET_WAIT, ras_miss_o tied to 0.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: I_HALT=0, I_NOP, I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OPQ, I_JXX, I_CALL, I_RET, I_PUSH, I_POP.
  - pc_state_t enum: RUN, RET_WAIT, HALTED, FAULT.
  - ifun constant J_ALWAYS=0.
- Sub-module pc_ras (parametrised LIFO with push, pop, flush, full and empty flags), instantiated only under PC_RAS_EN.

Test Plan:
- Reset, then irmovq (icode 3, valP=0x0A) accepted → pc_o=0x0A next cycle, count=1, state RUN.
- jXX ifun 1, valC=0x40, valP=0x13 → pc_o=0x40. Next cycle e_mispredict with e_alt_pc=0x13 and stall_i=1 → pc_o=0x13.
- ret at pc 0x20 → state RET_WAIT, fetch_en_o=0 for 3 cycles. m_ret_valid with 0x55 → pc_o=0x55, RUN.
- Accept with f_instr_invalid at pc 0x30 → state FAULT, fault_pc_o=0x30, count unchanged. Apply rst → pc_o=RESET_PC, count=0.
- halt at pc 0x08 → HALTED, pc_o=0x08 frozen for 10 cycles despite f_valid=1.
- PC_RAS_EN: call valC=0x100, valP=0x1A, then ret → pc_o=0x1A immediately. m_ret_valid with 0x1A → no ras_miss_o. Repeat with m_ret_addr=0x2B → pc_o=0x2B, ras_miss_o pulses once.
